// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the LC-3b CPU memory interface. Accepts one word
//   read or write request, waits LATENCY cycles, then pulses mem_resp for one
//   cycle. Writes honour the byte-lane mask. The word array is not reset.
//
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write; latches the request on acceptance
//   WAIT  | counting wait states; drops back to IDLE if the request disappears
//   RESP  | mem_resp high for this single cycle, then back to IDLE
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   mem_read        read request, held until mem_resp
//   mem_write       write request, held until mem_resp
//   mem_byte_enable write lane mask (bit0 = [7:0], bit1 = [15:8])
//   mem_address     byte address, bit 0 ignored, word index wraps at DEPTH_WORDS
//   mem_wdata       write data
//   mem_rdata       registered read data, updated only by completed reads
//   mem_resp        registered one-cycle completion pulse
//   protocol_err    sticky error flag, cleared only by reset
module mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  protocol_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_read;
    logic              lat_write;
    logic [IDX_W-1:0]  lat_idx;
    logic [15:0]       lat_wdata;
    logic [1:0]        lat_be;
    logic              resp_prev;

    logic [15:0]       mem_array [DEPTH_WORDS];

    logic              req_any;
    logic [IDX_W-1:0]  req_idx;
    logic              retrigger;
    logic              acc_go;
    logic              acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [15:0]       acc_wdata;
    logic [1:0]        acc_be;
    logic              unused_addr;

    // Only the low index bits select a word; the rest of the address wraps.
    assign unused_addr = ^mem_address;
    assign req_idx     = mem_address[IDX_W:1];
    assign req_any     = mem_read | mem_write;

    // A request still sitting on the bus right after a response, unchanged,
    // means the initiator failed to drop it in time.
    assign retrigger = resp_prev
                       && (mem_read == lat_read) && (mem_write == lat_write)
                       && (req_idx == lat_idx) && (mem_wdata == lat_wdata)
                       && (mem_byte_enable == lat_be);

    // acc_go marks the edge that enters RESP. With zero latency that edge is
    // the acceptance edge itself, so the live inputs are used instead of the
    // latched copy.
    always_comb begin
        acc_go    = 1'b0;
        acc_write = lat_write;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        case (state)
            IDLE: begin
                if (LATENCY == 0 && req_any) begin
                    acc_go    = 1'b1;
                    acc_write = mem_write;
                    acc_idx   = req_idx;
                    acc_wdata = mem_wdata;
                    acc_be    = mem_byte_enable;
                end
            end
            WAIT: begin
                if (req_any && cnt == '0) begin
                    acc_go = 1'b1;
                end
            end
            default: ;
        endcase
        // No array access while reset is asserted.
        if (!rst_n) begin
            acc_go = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            resp_prev    <= 1'b0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            protocol_err <= 1'b0;
        end else begin
            resp_prev <= mem_resp;
            mem_resp  <= acc_go;
            if (acc_go && !acc_write) begin
                mem_rdata <= mem_array[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req_any) begin
                        lat_read  <= mem_read;
                        lat_write <= mem_write;
                        lat_idx   <= req_idx;
                        lat_wdata <= mem_wdata;
                        lat_be    <= mem_byte_enable;
                        if ((mem_read && mem_write) || retrigger) begin
                            protocol_err <= 1'b1;
                        end
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req_any) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (acc_go && acc_write) begin
            if (acc_be[0]) begin
                mem_array[acc_idx][7:0] <= acc_wdata[7:0];
            end
            if (acc_be[1]) begin
                mem_array[acc_idx][15:8] <= acc_wdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: LATENCY = 3, instance b: LATENCY = 0
    logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
    logic [1:0]  a_be = 0, b_be = 0;
    logic [15:0] a_addr = 0, a_wd = 0, b_addr = 0, b_wd = 0;
    logic [15:0] a_rdata, b_rdata;
    logic        a_resp, a_err, b_resp, b_err;

    mem_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr),
        .mem_byte_enable(a_be), .mem_address(a_addr), .mem_wdata(a_wd),
        .mem_rdata(a_rdata), .mem_resp(a_resp), .protocol_err(a_err));

    mem_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr),
        .mem_byte_enable(b_be), .mem_address(b_addr), .mem_wdata(b_wd),
        .mem_rdata(b_rdata), .mem_resp(b_resp), .protocol_err(b_err));

    // reference model: word arrays and the last completed read per instance
    logic [15:0] mem_m [2][256];
    logic [15:0] last_rd [2];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit sel, input bit rd, input bit wr, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] wd);
        if (!sel) begin
            a_rd = rd; a_wr = wr; a_be = be; a_addr = addr; a_wd = wd;
        end else begin
            b_rd = rd; b_wr = wr; b_be = be; b_addr = addr; b_wd = wd;
        end
    endtask

    function automatic logic get_resp(input bit sel);
        return sel ? b_resp : a_resp;
    endfunction

    function automatic logic [15:0] get_rdata(input bit sel);
        return sel ? b_rdata : a_rdata;
    endfunction

    // One transaction. drop_at / chg_at (cycle numbers after acceptance, 0 = never)
    // abort the request or move its address while it waits.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input int drop_at, input int chg_at, input logic [15:0] chg_addr,
                       output logic [15:0] rdata);
        int n;
        bit got;
        int lat_exp;
        logic [7:0] widx;
        lat_exp = sel ? 1 : 4;
        widx = addr[8:1];
        n = 0;
        got = 0;
        @(negedge clk);
        set_req(sel, rd, wr, be, addr, wd);
        while (n < 12 && !got) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (get_resp(sel)) begin
                got = 1;
            end else begin
                if (n == drop_at) set_req(sel, 0, 0, 2'b00, 16'h0000, 16'h0000);
                if (n == chg_at)  set_req(sel, rd, wr, ~be, chg_addr, ~wd);
            end
        end
        rdata = get_rdata(sel);
        set_req(sel, 0, 0, 2'b00, 16'h0000, 16'h0000);
        if (drop_at > 0) begin
            check("abort_no_resp", {31'd0, got}, 32'd0);
            check("abort_rdata_held", {16'd0, rdata}, {16'd0, last_rd[sel]});
        end else begin
            check("resp_seen", {31'd0, got}, 32'd1);
            check("latency", n, lat_exp);
            if (wr) begin
                if (be[0]) mem_m[sel][widx][7:0]  = wd[7:0];
                if (be[1]) mem_m[sel][widx][15:8] = wd[15:8];
                check("wr_rdata_held", {16'd0, rdata}, {16'd0, last_rd[sel]});
            end else begin
                check("rd_model", {16'd0, rdata}, {16'd0, mem_m[sel][widx]});
                last_rd[sel] = mem_m[sel][widx];
            end
            @(posedge clk);
            @(negedge clk);
            check("resp_single_pulse", {31'd0, get_resp(sel)}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 0, 0, 2'b00, 16'h0000, 16'h0000);
        set_req(1, 0, 0, 2'b00, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
    endtask

    initial begin
        logic [15:0] rd_v;
        logic [15:0] instr [8];
        int n;
        bit got;

        vecs[0]  = '{0, 1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1, 0, 2'b00, 16'h0011, 16'h0000, 16'hBEEF};
        vecs[3]  = '{0, 1, 2'b11, 16'h0020, 16'h1234, 16'h0000};
        vecs[4]  = '{0, 1, 2'b01, 16'h0020, 16'hABCD, 16'h0000};
        vecs[5]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'h12CD};
        vecs[6]  = '{0, 1, 2'b10, 16'h0020, 16'hABCD, 16'h0000};
        vecs[7]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'hABCD};
        vecs[8]  = '{0, 1, 2'b00, 16'h0020, 16'h5555, 16'h0000};
        vecs[9]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'hABCD};
        vecs[10] = '{0, 1, 2'b11, 16'h0202, 16'hCAFE, 16'h0000};
        vecs[11] = '{1, 0, 2'b00, 16'h0002, 16'h0000, 16'hCAFE};

        apply_reset();
        @(negedge clk);
        check("rst_resp_a", {31'd0, a_resp}, 32'd0);
        check("rst_rdata_a", {16'd0, a_rdata}, 32'd0);
        check("rst_err_a", {31'd0, a_err}, 32'd0);
        check("rst_resp_b", {31'd0, b_resp}, 32'd0);
        check("rst_rdata_b", {16'd0, b_rdata}, 32'd0);
        check("rst_err_b", {31'd0, b_err}, 32'd0);

        // give every word of instance a a known value
        for (int i = 0; i < 256; i++) begin
            txn(0, 0, 1, 2'b11, 16'(i * 2), 16'($urandom), 0, 0, 16'h0000, rd_v);
        end

        // reset with a read held across it: nothing happens until release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        set_req(0, 1, 0, 2'b00, 16'h0010, 16'h0000);
        @(negedge clk);
        check("midrst_resp", {31'd0, a_resp}, 32'd0);
        check("midrst_rdata", {16'd0, a_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        got = 0;
        while (n < 12 && !got) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            got = a_resp;
        end
        check("post_rst_latency", n, 4);
        check("post_rst_rdata", {16'd0, a_rdata}, {16'd0, mem_m[0][8]});
        last_rd[0] = mem_m[0][8];
        set_req(0, 0, 0, 2'b00, 16'h0000, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_err", {31'd0, a_err}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            txn(0, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wd, 0, 0, 16'h0000, rd_v);
            if (vecs[i].rd) check($sformatf("table_rd%0d", i), {16'd0, rd_v}, {16'd0, vecs[i].exp});
        end

        // abort after one wait cycle: no write, next read returns old value
        txn(0, 0, 1, 2'b11, 16'h0020, 16'h0BAD, 1, 0, 16'h0000, rd_v);
        txn(0, 1, 0, 2'b00, 16'h0020, 16'h0000, 0, 0, 16'h0000, rd_v);
        check("abort_old_value", {16'd0, rd_v}, 32'h0000ABCD);

        // address change mid-wait is ignored
        txn(0, 1, 0, 2'b00, 16'h0010, 16'h0000, 0, 1, 16'h0020, rd_v);
        check("addr_change_ignored", {16'd0, rd_v}, 32'h0000BEEF);

        // read+write together: performed as a write and flagged
        check("err_before_conflict", {31'd0, a_err}, 32'd0);
        txn(0, 1, 1, 2'b11, 16'h0050, 16'h4242, 0, 0, 16'h0000, rd_v);
        check("err_after_conflict", {31'd0, a_err}, 32'd1);
        txn(0, 1, 0, 2'b00, 16'h0050, 16'h0000, 0, 0, 16'h0000, rd_v);
        check("conflict_wrote", {16'd0, rd_v}, 32'h00004242);

        // randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            txn(0, !w, w, 2'($urandom), 16'($urandom), 16'($urandom), 0, 0, 16'h0000, rd_v);
        end
        check("err_sticky", {31'd0, a_err}, 32'd1);

        // zero-latency instruction fetch loop
        for (int i = 0; i < 8; i++) begin
            instr[i] = 16'h1000 + 16'(i * 16'h0123);
            txn(1, 0, 1, 2'b11, 16'h3000 + 16'(i * 2), instr[i], 0, 0, 16'h0000, rd_v);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); // fetch1: MAR <- PC, no request
            txn(1, 1, 0, 2'b00, 16'h3000 + 16'(i * 2), 16'h0000, 0, 0, 16'h0000, rd_v);
            check($sformatf("fetch%0d", i), {16'd0, rd_v}, {16'd0, instr[i]});
            @(negedge clk); // fetch3: IR <- MDR
        end
        check("fetch_no_err", {31'd0, b_err}, 32'd0);

        apply_reset();
        @(negedge clk);
        check("err_cleared_by_reset", {31'd0, a_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
